bpsk_tx_scheduler: RTL
======================

# bpsk_tx_scheduler

Transmit-side scheduler for the BPSK modulator. Arbitrates round-robin between several word sources and accepts one 16-bit word at a time through a valid/ready handshake. It then serialises that word LSB-first onto the modulator's data-bit input, holding each bit for a programmable number of clocks. It replaces ad-hoc load/shift logic in front of the sine/phase stage and owns symbol timing, so the modulator runs on a single clock.

## Interface
Parameters:
- WORD_W, 16, bits per word; range 2..32.
- NUM_REQ, 2, number of requesters; range 2..8.
- SYM_DIV, 2, clock cycles per symbol; range 1..256.
- PREAMBLE, 8'hAA, preamble pattern, sent LSB-first; used only with preamble feature.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester word-valid.
- req_data  in  NUM_REQ*WORD_W  requester k occupies bits [k*WORD_W +: WORD_W].
- req_ready  out  NUM_REQ  one-hot or zero; a word transfers when valid&ready are high on the same edge.
- d_bit  out  1  bit driven to the modulator.
- sym_stb  out  1  one-cycle pulse on the first cycle of every symbol.
- busy  out  1  high while a symbol is being driven.
- grant_id  out  $clog2(NUM_REQ)  source index of the word in flight.
- word_done  out  1  one-cycle pulse on the last cycle of a word's last symbol.

## Operation
- States: IDLE, PRE (feature only), DATA.
- Arbiter: round-robin pointer rr, reset 0. Winner is the first requester with valid set, searching from rr upward with wrap. After each accepted word, rr becomes winner+1 mod NUM_REQ.
- req_ready[winner] is high only when state==IDLE or in the last cycle of the final DATA symbol (accept window). It is combinational from req_valid and rr. At most one bit of req_ready is set. Outside the window, req_ready is 0.
- On accept: latch word into shift register, set grant_id=winner, and reset the bit counter and the cycle counter. Next state is PRE if the feature is enabled, else DATA.
- Symbol progression: cycle counter counts 0..SYM_DIV-1. At wrap, advance to the next bit.
- In PRE, send PREAMBLE[0..7], then enter DATA.
- In DATA, send word[0..WORD_W-1]. All WORD_W bits are sent; none are dropped.
- End of word: if an accept happens in the window, the next word's first symbol starts on the next cycle with no gap. Otherwise the block returns to IDLE.
- In IDLE: d_bit=0, busy=0, sym_stb=0. grant_id holds its last value.
- Requester behaviour: a requester that drops valid without a handshake is simply skipped. req_data is sampled only at the accepting edge.

## Timing
- Reset values: d_bit=0, sym_stb=0, busy=0, grant_id=0, word_done=0, req_ready follows arbiter (state IDLE). Shift register, counters and rr are cleared.
- Reset mid-word: the word is discarded immediately (asynchronous). There is no word_done. The block restarts in IDLE.
- Latency: accept edge to first sym_stb/d_bit is 1 cycle (registered outputs).
- Word duration: WORD_W*SYM_DIV cycles, plus 8*SYM_DIV cycles with preamble.
- With SYM_DIV=1, sym_stb is high every busy cycle.
- Back-to-back: word_done and the next accept occur in the same cycle. busy stays high continuously.
- Simultaneous valid from all requesters: exactly one is granted per word, in rotating order.

## Configuration
- BPSK_TX_PREAMBLE_EN defined: the PRE state exists and every word is prefixed with 8 symbols of PREAMBLE.
- BPSK_TX_PREAMBLE_EN undefined: there is no PRE state and the PREAMBLE parameter is ignored. Accept goes directly to DATA.

## Structure
- Package bpsk_pkg holds:
  - the state enum (IDLE/PRE/DATA);
  - the default WORD_W;
  - the PREAMBLE default (8'hAA) and preamble length constant (8).
- One sub-module, bpsk_rr_arbiter: parameter NUM_REQ. Inputs are req, pointer and advance. Outputs are a one-hot grant and an index.

## Test plan
- Single word, defaults, preamble off: requester 0 sends 16'h00F1 → d_bit = 1,0,0,0,1,1,1,1 then 8 zeros, 2 cycles each. There are 16 sym_stb pulses, word_done pulses at cycle 32, then IDLE.
- Both requesters valid continuously (words 16'hAAAA, 16'h5555) → grants alternate 0,1,0,1. busy is never deasserted and there is no cycle gap between words.
- SYM_DIV=1, WORD_W=16 → word_done 16 cycles after first sym_stb. The next accept occurs in that same cycle.
- Assert rst low at bit 7 of a word → outputs go to reset values at once. There is no word_done. After release, a new word starts from bit 0 with rr=0.
- BPSK_TX_PREAMBLE_EN defined, word 16'h0001 → 8 symbols 0,1,0,1,0,1,0,1 (8'hAA, LSB-first), then 1 followed by fifteen 0s. Total 24*SYM_DIV cycles.
- Requester 1 pulses valid for one cycle while a word is mid-transmission → no handshake occurs and requester 1 is not granted later.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared constants and state encoding for the BPSK transmit scheduler.
package bpsk_pkg;

   // Legacy-compatible state encoding: IDLE / PRE / DATA.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_PRE  = 2'd1;
   localparam state_t ST_DATA = 2'd2;

   localparam int unsigned DEF_WORD_W   = 16;
   localparam logic [7:0]  DEF_PREAMBLE = 8'hAA;
   localparam int unsigned PRE_LEN      = 8;

endpackage

// File: rtl/bpsk_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
// grant is one-hot and only asserted while advance is high; idx is always valid
// for the current winner so the caller can update its pointer on a handshake.
module bpsk_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   // Search upward from ptr, wrapping, and pick the first active request.
   always_comb begin
      logic        found;
      int unsigned k;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = (32'(ptr) + i) % NUM_REQ;
         if (!found && req[IDX_W'(k)]) begin
            found              = 1'b1;
            grant[IDX_W'(k)]   = advance;
            idx                = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Transmit scheduler for the BPSK modulator: round-robin word intake and
// LSB-first serialisation, SYM_DIV clocks per symbol.
// Optional feature: define BPSK_TX_PREAMBLE_EN to prefix every word with the
// 8-symbol PREAMBLE pattern (PRE state).
module bpsk_tx_scheduler
   import bpsk_pkg::*;
#(
   parameter int unsigned WORD_W   = DEF_WORD_W,
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned SYM_DIV  = 2,
   parameter logic [7:0]  PREAMBLE = DEF_PREAMBLE,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*WORD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      d_bit,
   output logic                      sym_stb,
   output logic                      busy,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      word_done
);

   localparam int unsigned CYC_W   = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
   // Bit counter must also cover the 8 preamble symbols.
   localparam int unsigned BIT_MAX = (WORD_W > PRE_LEN) ? WORD_W : PRE_LEN;
   localparam int unsigned BIT_W   = $clog2(BIT_MAX);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [IDX_W-1:0]    gid_q, gid_d;

   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    win_idx;
   logic [WORD_W-1:0]   win_word;
   logic                sym_last, pre_last, word_last, window, accept;

   assign sym_last  = (cyc_q == CYC_W'(SYM_DIV - 1));
   assign pre_last  = (state_q == ST_PRE) && (bit_q == BIT_W'(PRE_LEN - 1)) && sym_last;
   assign word_last = (state_q == ST_DATA) && (bit_q == BIT_W'(WORD_W - 1)) && sym_last;
   // Accept window: idle, or the very last cycle of a word so the next one follows gap-free.
   assign window    = (state_q == ST_IDLE) || word_last;
   assign accept    = |grant;

   bpsk_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_q),
      .advance (window),
      .grant   (grant),
      .idx     (win_idx)
   );

   // Select the winning requester's word (grant is one-hot or zero).
   always_comb begin
      win_word = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) win_word = win_word | req_data[k*WORD_W +: WORD_W];
      end
   end

   // Next-state: intake on accept, otherwise symbol/bit progression.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      if (accept) begin
         shreg_d = win_word;
         bit_d   = '0;
         cyc_d   = '0;
         gid_d   = win_idx;
         rr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef BPSK_TX_PREAMBLE_EN
         state_d = ST_PRE;
`else
         state_d = ST_DATA;
`endif
      end else if (state_q != ST_IDLE) begin
         if (!sym_last) begin
            cyc_d = cyc_q + 1'b1;
         end else begin
            cyc_d = '0;
            if (pre_last) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end else if (word_last) begin
               state_d = ST_IDLE;
            end else begin
               bit_d = bit_q + 1'b1;
               if (state_q == ST_DATA) shreg_d = shreg_q >> 1;
            end
         end
      end
   end

   // State registers; reset discards any word in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         rr_q    <= '0;
         gid_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
      end
   end

   // Outputs decode registered state only, so they change one cycle after accept.
   always_comb begin
      d_bit = 1'b0;
      if (state_q == ST_PRE)       d_bit = PREAMBLE[bit_q[2:0]];
      else if (state_q == ST_DATA) d_bit = shreg_q[0];
   end

   assign busy      = (state_q != ST_IDLE);
   assign sym_stb   = busy && (cyc_q == '0);
   assign word_done = word_last;
   assign grant_id  = gid_q;
   assign req_ready = grant;

endmodule
